// File: rtl/cpu_pkg.sv
// cpu_pkg: shared datapath widths and register-address type for the CPU pipeline
package cpu_pkg;
  localparam int DATA_WIDTH = 32;
  localparam int REG_ADDR_WIDTH = 5;
  typedef logic [REG_ADDR_WIDTH-1:0] reg_addr_t;
  localparam reg_addr_t ZERO_REG = '0;
endpackage

// File: rtl/wb_mux.sv
// wb_mux: MemToReg select between ALU result and load data for write-back
module wb_mux #(
  parameter int DATA_WIDTH = cpu_pkg::DATA_WIDTH
) (
  input  logic                  mem_to_reg,
  input  logic [DATA_WIDTH-1:0] alu_result,
  input  logic [DATA_WIDTH-1:0] mem_data,
  output logic [DATA_WIDTH-1:0] wb_data
);
  always_comb wb_data = mem_to_reg ? mem_data : alu_result;
endmodule

// File: rtl/writeback_regfile.sv
// writeback_regfile: write-back stage plus 2-read/1-write register file with retire counter
// Define WB_BYPASS_EN to forward the in-flight write-back value to same-cycle reads.
module writeback_regfile #(
  parameter int DATA_WIDTH = cpu_pkg::DATA_WIDTH,
  parameter int NUM_REGS = 32
) (
  input  logic                  Clock,
  input  logic                  Reset_n,
  input  logic                  RegWriteIn,
  input  logic                  MemToRegIn,
  input  logic [31:0]           WriteRegisterIn,
  input  logic [DATA_WIDTH-1:0] ALUResultIn,
  input  logic [DATA_WIDTH-1:0] DataMemoryIn,
  input  logic [4:0]            ReadRegister1,
  input  logic [4:0]            ReadRegister2,
  output logic [DATA_WIDTH-1:0] ReadData1,
  output logic [DATA_WIDTH-1:0] ReadData2,
  output logic [DATA_WIDTH-1:0] WriteBackData,
  output logic [31:0]           RetireCount
);
  import cpu_pkg::*;
  reg_addr_t waddr;
  logic commit;
  logic unused_waddr_hi;
  logic [DATA_WIDTH-1:0] regs [NUM_REGS];
  assign waddr = WriteRegisterIn[REG_ADDR_WIDTH-1:0];
  assign unused_waddr_hi = ^WriteRegisterIn[31:REG_ADDR_WIDTH];
  assign commit = RegWriteIn && waddr != ZERO_REG;
  wb_mux #(.DATA_WIDTH(DATA_WIDTH)) u_wb_mux (
    .mem_to_reg(MemToRegIn),
    .alu_result(ALUResultIn),
    .mem_data  (DataMemoryIn),
    .wb_data   (WriteBackData)
  );
  always_ff @(posedge Clock or negedge Reset_n)
    if (!Reset_n) begin
      for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
      RetireCount <= '0;
    end else if (commit) begin
      regs[waddr] <= WriteBackData;
      RetireCount <= RetireCount + 32'd1;
    end
`ifdef WB_BYPASS_EN
  always_comb begin
    ReadData1 = ReadRegister1 == ZERO_REG ? '0 : commit && waddr == ReadRegister1 ? WriteBackData : regs[ReadRegister1];
    ReadData2 = ReadRegister2 == ZERO_REG ? '0 : commit && waddr == ReadRegister2 ? WriteBackData : regs[ReadRegister2];
  end
`else
  always_comb begin
    ReadData1 = ReadRegister1 == ZERO_REG ? '0 : regs[ReadRegister1];
    ReadData2 = ReadRegister2 == ZERO_REG ? '0 : regs[ReadRegister2];
  end
`endif
endmodule

// File: tb/tb_writeback_regfile.sv
// tb_writeback_regfile: scoreboard bench for writeback_regfile (honours WB_BYPASS_EN)
module tb_writeback_regfile;
  typedef struct packed {
    logic [4:0]  addr;
    logic [31:0] data;
    logic [31:0] count;
  } exp_t;
  logic clk = 0, rst_n = 1, we = 0, m2r = 0;
  logic [31:0] wreg = 0, alu = 0, mem = 0;
  logic [4:0] rr1 = 0, rr2 = 0;
  logic [31:0] rd1, rd2, wbd, rc;
  logic [31:0] model [32];
  logic [31:0] mcount;
  exp_t sb[$];
  exp_t e;
  int errors = 0, checks = 0;

  writeback_regfile dut (
    .Clock(clk), .Reset_n(rst_n), .RegWriteIn(we), .MemToRegIn(m2r),
    .WriteRegisterIn(wreg), .ALUResultIn(alu), .DataMemoryIn(mem),
    .ReadRegister1(rr1), .ReadRegister2(rr2),
    .ReadData1(rd1), .ReadData2(rd2), .WriteBackData(wbd), .RetireCount(rc)
  );

  always #5 clk = ~clk;

  task automatic model_reset();
    for (int i = 0; i < 32; i++) model[i] = 0;
    mcount = 0;
    sb.delete();
  endtask

  task automatic drive(input logic w, input logic s, input logic [31:0] r, input logic [31:0] a, input logic [31:0] m);
    we = w; m2r = s; wreg = r; alu = a; mem = m;
    if (w && r[4:0] != 0) begin
      model[r[4:0]] = s ? m : a;
      mcount = mcount + 1;
    end
    sb.push_back('{addr: r[4:0], data: model[r[4:0]], count: mcount});
  endtask

  task automatic tick();
    @(posedge clk); #1;
    we = 0;
  endtask

  task automatic test_reset();
    rr1 = 5; rr2 = 0;
    #1 rst_n = 0;
    we = 1; wreg = 5; alu = 32'h99;
    repeat (2) @(posedge clk);
    #1;
    checks++; if (rd1 !== 32'h0) begin errors++; $display("FAIL reset_read: got %h expected %h", rd1, 32'h0); end
    checks++; if (rc !== 32'h0) begin errors++; $display("FAIL reset_count: got %h expected %h", rc, 32'h0); end
    we = 0;
    rst_n = 1;
    model_reset();
  endtask

  task automatic test_alu_write();
    drive(1, 0, 5, 32'h1234, 32'hFFFF_0000);
    #1;
    checks++; if (wbd !== 32'h1234) begin errors++; $display("FAIL wbdata_alu: got %h expected %h", wbd, 32'h1234); end
    tick();
    e = sb.pop_front();
    rr1 = e.addr; #1;
    checks++; if (rd1 !== e.data) begin errors++; $display("FAIL alu_write: got %h expected %h", rd1, e.data); end
    checks++; if (rc !== e.count) begin errors++; $display("FAIL alu_count: got %h expected %h", rc, e.count); end
  endtask

  task automatic test_mem_write();
    drive(1, 1, 32'h0000_00E7, 32'h5555, 32'hDEAD_BEEF);
    #1;
    checks++; if (wbd !== 32'hDEAD_BEEF) begin errors++; $display("FAIL wbdata_mem: got %h expected %h", wbd, 32'hDEAD_BEEF); end
    tick();
    e = sb.pop_front();
    rr2 = e.addr; #1;
    checks++; if (rd2 !== e.data) begin errors++; $display("FAIL mem_write: got %h expected %h", rd2, e.data); end
    checks++; if (rc !== e.count) begin errors++; $display("FAIL mem_count: got %h expected %h", rc, e.count); end
  endtask

  task automatic test_zero_reg();
    logic [31:0] regs_hi [2];
    regs_hi[0] = 32'h0;
    regs_hi[1] = 32'hFFFF_FFE0;
    for (int k = 0; k < 2; k++) begin
      drive(1, 0, regs_hi[k], 32'hFFFF, 0);
      tick();
      e = sb.pop_front();
      rr1 = 0; rr2 = e.addr; #1;
      checks++; if (rd1 !== 32'h0) begin errors++; $display("FAIL zero_read1: got %h expected %h", rd1, 32'h0); end
      checks++; if (rd2 !== e.data) begin errors++; $display("FAIL zero_read2: got %h expected %h", rd2, e.data); end
      checks++; if (rc !== e.count) begin errors++; $display("FAIL zero_count: got %h expected %h", rc, e.count); end
    end
  endtask

  task automatic test_upper_bits();
    drive(1, 0, {$urandom_range(1, 32'h7FF_FFFF), 5'd3}, 32'h0BAD_F00D, 0);
    tick();
    e = sb.pop_front();
    rr1 = 3; #1;
    checks++; if (rd1 !== e.data) begin errors++; $display("FAIL upper_bits: got %h expected %h", rd1, e.data); end
  endtask

  task automatic test_bypass();
    logic [31:0] old, exp;
    drive(1, 0, 9, 32'h11, 0);
    tick();
    e = sb.pop_front();
    old = model[9];
    rr2 = 9; rr1 = 0;
    drive(1, 0, 9, 32'hAA, 0);
    #1;
`ifdef WB_BYPASS_EN
    exp = 32'hAA;
`else
    exp = old;
`endif
    checks++; if (rd2 !== exp) begin errors++; $display("FAIL bypass_read: got %h expected %h", rd2, exp); end
    checks++; if (rd1 !== 32'h0) begin errors++; $display("FAIL bypass_zero: got %h expected %h", rd1, 32'h0); end
    tick();
    e = sb.pop_front();
    #1;
    checks++; if (rd2 !== e.data) begin errors++; $display("FAIL bypass_stored: got %h expected %h", rd2, e.data); end
    drive(1, 0, 0, 32'h77, 0);
    #1;
    checks++; if (rd1 !== 32'h0) begin errors++; $display("FAIL bypass_r0: got %h expected %h", rd1, 32'h0); end
    tick();
    e = sb.pop_front();
  endtask

  task automatic test_back_to_back();
    for (int n = 0; n < 40; n++) begin
      drive($urandom_range(0, 3) != 0, $urandom_range(0, 1) == 1, $urandom, $urandom, $urandom);
      tick();
      e = sb.pop_front();
      rr1 = e.addr; rr2 = e.addr; #1;
      checks++; if (rd1 !== e.data) begin errors++; $display("FAIL b2b_read1 r%0d: got %h expected %h", e.addr, rd1, e.data); end
      checks++; if (rd2 !== e.data) begin errors++; $display("FAIL b2b_read2 r%0d: got %h expected %h", e.addr, rd2, e.data); end
      checks++; if (rc !== e.count) begin errors++; $display("FAIL b2b_count: got %h expected %h", rc, e.count); end
    end
  endtask

  task automatic test_async_reset();
    drive(1, 0, 12, 32'hCAFE, 0);
    tick();
    e = sb.pop_front();
    rr1 = 12; rr2 = 7; #1;
    rst_n = 0; #1;
    checks++; if (rd1 !== 32'h0) begin errors++; $display("FAIL async_read1: got %h expected %h", rd1, 32'h0); end
    checks++; if (rd2 !== 32'h0) begin errors++; $display("FAIL async_read2: got %h expected %h", rd2, 32'h0); end
    checks++; if (rc !== 32'h0) begin errors++; $display("FAIL async_count: got %h expected %h", rc, 32'h0); end
    model_reset();
    we = 1; wreg = 4; alu = 32'h44; m2r = 0; rr1 = 4;
    @(posedge clk); #1;
    checks++; if (rd1 !== 32'h0) begin errors++; $display("FAIL reset_wins: got %h expected %h", rd1, 32'h0); end
    we = 0;
    rst_n = 1;
    drive(1, 0, 4, 32'h77, 0);
    tick();
    e = sb.pop_front();
    #1;
    checks++; if (rd1 !== e.data) begin errors++; $display("FAIL first_write: got %h expected %h", rd1, e.data); end
    checks++; if (rc !== e.count) begin errors++; $display("FAIL first_count: got %h expected %h", rc, e.count); end
  endtask

  task automatic test_wrap();
    force dut.RetireCount = 32'hFFFF_FFFF;
    #1;
    release dut.RetireCount;
    mcount = 32'hFFFF_FFFF;
    drive(1, 0, 3, 32'h33, 0);
    tick();
    e = sb.pop_front();
    rr1 = 3; #1;
    checks++; if (rc !== e.count) begin errors++; $display("FAIL wrap_count: got %h expected %h", rc, e.count); end
    checks++; if (rd1 !== e.data) begin errors++; $display("FAIL wrap_write: got %h expected %h", rd1, e.data); end
  endtask

  initial begin
    model_reset();
    test_reset();
    test_alu_write();
    test_mem_write();
    test_zero_reg();
    test_upper_bits();
    test_bypass();
    test_back_to_back();
    test_async_reset();
    test_wrap();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
